reg_bus_server: RTL and testbench
=================================

// Module: reg_bus_server
// PURPOSE
//   Register-block responder sitting directly upstream of the tt_um_warriorjacq9 core's ALU.
//   Watches the core's 4-bit BUSREQ code (uo_out[3:0]) and services it:
//   - supplies the next register index on ui_in[7:4];
//   - drives the selected register value onto uio_in;
//   - captures ALU results (uio_out) back into the register file.
//   Holds a host-loaded operand-index queue and a NUM_REGS x DATA_W register file.
// PARAMETERS
//   NUM_REGS   16  register count (power of 2, index width IDX_W = $clog2(NUM_REGS))
//   DATA_W     8   register/data width; must be >= 4
//   OPQ_DEPTH  8   operand-index queue depth (power of 2, >= 2)
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous reset, active-high
//   busreq      in   4       BUSREQ code from core (uo_out[3:0])
//   alu_result  in   DATA_W  core result bus (uio_out)
//   operand     out  IDX_W   register index to core (ui_in[7:4])
//   regval      out  DATA_W  register value to core (uio_in)
//   resp_valid  out  1       1-cycle strobe: operand/regval updated this cycle
//   op_push     in   1       host: push op_idx into operand queue
//   op_idx      in   IDX_W   host: index to push
//   cfg_we      in   1       host: preload write enable
//   cfg_addr    in   IDX_W   host: preload address
//   cfg_data    in   DATA_W  host: preload data
//   q_count     out  $clog2(OPQ_DEPTH)+1  queue occupancy
//   err_ovf     out  1       sticky: push while full and no pop
//   err_unf     out  1       sticky: NEXT_OP while queue empty
// BEHAVIOUR
//   Reset (async, immediate):
//   - operand, regval, resp_valid, q_count, err_* = 0;
//   - all registers = 0; busreq_q = 0; FSM -> IDLE.
//   Request detect:
//   - busreq_q registers busreq every cycle;
//   - a request is accepted only when busreq != busreq_q and FSM is IDLE;
//   - a held code is serviced once; re-issue needs a change.
//   - Changes arriving while not IDLE are dropped, not queued.
//   BUSREQ codes:
//   - 0000 NOP;
//   - 0011 NEXT_OP;
//   - 0001 READ;
//   - 0010 WRITE;
//   - all other codes ignored (no state change).
//   FSM states: IDLE -> DECODE -> {POP | READ | WRITE} -> IDLE.
//   - DECODE (cycle 1 after accept): latch code.
//   - POP (cycle 2):
//     - if q_count > 0: sel <= queue head, operand <= head, pop;
//     - if q_count == 0: operand <= 0, sel <= 0, err_unf <= 1.
//     - resp_valid = 1.
//   - READ (cycle 2): regval <= regs[sel]; resp_valid = 1.
//   - WRITE (cycle 2): regs[sel] <= alu_result, sampled in this cycle; resp_valid stays 0.
//   - Latency: accept edge + 2 cycles to visible response. Outputs hold until next update.
//   Queue:
//   - circular FIFO; read/write pointers wrap modulo OPQ_DEPTH.
//   - push while full with simultaneous pop: both succeed, count unchanged.
//   - push while full without pop: dropped, err_ovf <= 1.
//   - err flags clear only on rst.
//   Preload:
//   - cfg_we writes regs[cfg_addr] in any state.
//   - same cycle/same address as a WRITE state: core write wins.
//   - READ of an address preloaded in the same cycle returns the old value.
//   Reset mid-operation aborts the transaction; no partial register write.
// CONFIGURATION
//   RB_ZERO_REG_EN
//   - defined: register 0 reads as 0; WRITE and cfg_we to index 0 are discarded.
//   - undefined: register 0 is an ordinary register.
// TESTING
//   1. Preload reg1=4; push idx 1; busreq 0000->0011
//      -> 2 cycles later operand=1, resp_valid pulse, q_count 1->0.
//   2. Then busreq 0011->0001 -> regval=4 after 2 cycles.
//      Then busreq ->0010 with alu_result=6 -> reg1=6; next READ gives 6.
//   3. Empty queue, busreq ->0011
//      -> operand=0, err_unf=1, stays 1 until rst.
//   4. Push 9 indices (OPQ_DEPTH=8) -> err_ovf=1, q_count=8.
//      Push+pop same cycle at full -> count stays 8.
//      8 pops return pushes 1..8 in order (wrap check).
//   5. Hold busreq=0001 for 10 cycles -> exactly one resp_valid pulse.
//      Code 0101 -> no response, no state change.
//   6. Assert rst during WRITE state -> target register unchanged (0), all outputs 0 immediately.
//      Build with RB_ZERO_REG_EN: WRITE 6 to reg0 then READ -> regval=0.

Source files
------------

// File: rtl/reg_bus_server_if.sv
// reg_bus_server_if: core BUSREQ handshake plus host queue/preload bus for reg_bus_server
interface reg_bus_server_if #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 8,
  parameter int OPQ_DEPTH = 8
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(OPQ_DEPTH) + 1;
  logic [3:0]        busreq;
  logic [DATA_W-1:0] alu_result;
  logic [IDX_W-1:0]  operand;
  logic [DATA_W-1:0] regval;
  logic              resp_valid;
  logic              op_push;
  logic [IDX_W-1:0]  op_idx;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [CNT_W-1:0]  q_count;
  logic              err_ovf;
  logic              err_unf;
  modport slave (
    input  busreq, alu_result, op_push, op_idx, cfg_we, cfg_addr, cfg_data,
    output operand, regval, resp_valid, q_count, err_ovf, err_unf
  );
  modport master (
    output busreq, alu_result, op_push, op_idx, cfg_we, cfg_addr, cfg_data,
    input  operand, regval, resp_valid, q_count, err_ovf, err_unf
  );
endinterface

// File: rtl/reg_bus_server.sv
// reg_bus_server: services core BUSREQ codes from an operand-index queue and register file (optional RB_ZERO_REG_EN hardwires register 0 to zero)
module reg_bus_server #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 8,
  parameter int OPQ_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  reg_bus_server_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(OPQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] C_READ = 4'b0001;
  localparam logic [3:0] C_WRITE = 4'b0010;
  localparam logic [3:0] C_NEXT = 4'b0011;
`ifdef RB_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DECODE, POP, READ, WRITE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        code_q, code_d, busreq_q;
  logic [IDX_W-1:0]  sel_q, operand_q;
  logic [DATA_W-1:0] regval_q;
  logic              resp_q, ovf_q, unf_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [IDX_W-1:0]  fifo_q [OPQ_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pop, push, full, known, cfg_ok, core_ok;
  logic [DATA_W-1:0] rd_val;
  // request acceptance and sequencing; only a changed, recognised code starts a transaction
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    known   = bus.busreq == C_READ || bus.busreq == C_WRITE || bus.busreq == C_NEXT;
    case (state_q)
      IDLE: if (bus.busreq != busreq_q && known) begin
        state_d = DECODE;
        code_d  = bus.busreq;
      end
      DECODE: state_d = code_q == C_NEXT ? POP : code_q == C_READ ? READ : WRITE;
      default: state_d = IDLE;
    endcase
  end
  // queue and register-file control terms
  always_comb begin
    full    = cnt_q == CNT_W'(OPQ_DEPTH);
    pop     = state_q == POP && cnt_q != '0;
    push    = bus.op_push && (!full || pop);
    cfg_ok  = !(ZERO_REG && bus.cfg_addr == '0);
    core_ok = !(ZERO_REG && sel_q == '0);
    rd_val  = (ZERO_REG && sel_q == '0) ? '0 : regs_q[sel_q];
  end
  // FSM, response outputs, queue pointers and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      busreq_q  <= '0;
      sel_q     <= '0;
      operand_q <= '0;
      regval_q  <= '0;
      resp_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      busreq_q <= bus.busreq;
      resp_q   <= state_q == POP || state_q == READ;
      if (state_q == POP) begin
        sel_q     <= pop ? fifo_q[rp_q] : '0;
        operand_q <= pop ? fifo_q[rp_q] : '0;
        unf_q     <= unf_q | !pop;
      end
      if (state_q == READ) regval_q <= rd_val;
      if (bus.op_push && full && !pop) ovf_q <= 1'b1;
      wp_q  <= wp_q + PTR_W'(push);
      rp_q  <= rp_q + PTR_W'(pop);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // operand queue storage; occupancy lives in the control block
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= bus.op_idx;
  end
  // register file: host preload first so a same-cycle core write overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (bus.cfg_we && cfg_ok) regs_q[bus.cfg_addr] <= bus.cfg_data;
      if (state_q == WRITE && core_ok) regs_q[sel_q] <= bus.alu_result;
    end
  end
  assign bus.operand    = operand_q;
  assign bus.regval     = regval_q;
  assign bus.resp_valid = resp_q;
  assign bus.q_count    = cnt_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_unf    = unf_q;
endmodule

// File: tb/tb_reg_bus_server.sv
// tb_reg_bus_server: randomized scoreboard bench for reg_bus_server against a queue/array reference model
module tb_reg_bus_server;
  localparam int NR = 16;
  localparam int DW = 8;
  localparam int QD = 8;
  typedef struct packed {logic [3:0] op; logic [7:0] rv;} resp_t;
`ifdef RB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  resp_t sb[$];
  resp_t exp_r;
  logic [7:0] m_regs [NR];
  logic [3:0] m_q[$];
  logic [3:0] m_sel;
  logic [7:0] m_rv;
  bit m_ovf, m_unf;
  always #5 clk = ~clk;
  reg_bus_server_if #(.NUM_REGS(NR), .DATA_W(DW), .OPQ_DEPTH(QD)) bus ();
  reg_bus_server #(.NUM_REGS(NR), .DATA_W(DW), .OPQ_DEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bool_w(input logic [3:0] a);
    return !(ZERO_EN && a == 4'd0);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_q.delete();
    sb.delete();
    m_sel = '0;
    m_rv = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic check_status(input string tag);
    chk({tag, "_q_count"}, bus.q_count, m_q.size());
    chk({tag, "_err_ovf"}, bus.err_ovf, m_ovf);
    chk({tag, "_err_unf"}, bus.err_unf, m_unf);
  endtask
  // monitor: every response strobe is matched against the oldest expected response
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        exp_r = sb.pop_front();
        chk("resp_operand", bus.operand, exp_r.op);
        chk("resp_regval", bus.regval, exp_r.rv);
      end
    end
  end
  task automatic push_idx(input logic [3:0] idx);
    @(posedge clk); #1;
    bus.op_push = 1'b1;
    bus.op_idx = idx;
    if (m_q.size() < QD) m_q.push_back(idx); else m_ovf = 1'b1;
    @(posedge clk); #1;
    bus.op_push = 1'b0;
  endtask
  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    if (bool_w(a)) m_regs[a] = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask
  // one bus transaction; optional host push / preload land in the service cycle
  task automatic issue(input logic [3:0] code, input logic [7:0] alu, input bit dp, input logic [3:0] pidx,
                       input bit dc, input logic [3:0] ca, input logic [7:0] cd);
    @(posedge clk); #1;
    if (bus.busreq == code) begin
      bus.busreq = 4'd0;
      @(posedge clk); #1;
    end
    bus.busreq = code;
    bus.alu_result = alu;
    @(posedge clk);
    @(posedge clk); #1;
    bus.op_push = dp;
    bus.op_idx = pidx;
    bus.cfg_we = dc;
    bus.cfg_addr = ca;
    bus.cfg_data = cd;
    if (code == 4'd3) begin
      if (m_q.size() > 0) m_sel = m_q.pop_front();
      else begin
        m_sel = '0;
        m_unf = 1'b1;
      end
      sb.push_back('{op: m_sel, rv: m_rv});
    end else if (code == 4'd1) begin
      m_rv = bool_w(m_sel) ? m_regs[m_sel] : 8'd0;
      sb.push_back('{op: m_sel, rv: m_rv});
    end
    if (dp) begin
      if (m_q.size() < QD) m_q.push_back(pidx); else m_ovf = 1'b1;
    end
    if (dc && bool_w(ca)) m_regs[ca] = cd;
    if (code == 4'd2 && bool_w(m_sel)) m_regs[m_sel] = alu;
    @(posedge clk); #1;
    bus.op_push = 1'b0;
    bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    chk("resp_drained", sb.size(), 0);
  endtask
  task automatic req(input logic [3:0] code, input logic [7:0] alu);
    issue(code, alu, 1'b0, 4'd0, 1'b0, 4'd0, 8'd0);
  endtask
  initial begin
    bus.busreq = '0;
    bus.alu_result = '0;
    bus.op_push = 1'b0;
    bus.op_idx = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_operand", bus.operand, 0);
    chk("rst_regval", bus.regval, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    check_status("rst");
    rst = 1'b0;
    preload(4'd1, 8'd4);
    push_idx(4'd1);
    chk("t1_q_before", bus.q_count, 1);
    req(4'd3, 8'd0);
    check_status("t1");
    req(4'd1, 8'd0);
    req(4'd2, 8'd6);
    req(4'd1, 8'd0);
    check_status("t2");
    req(4'd3, 8'd0);
    check_status("t3");
    for (int i = 1; i <= 9; i++) push_idx(4'(i));
    check_status("t4_full");
    issue(4'd3, 8'd0, 1'b1, 4'd10, 1'b0, 4'd0, 8'd0);
    check_status("t4_pushpop");
    for (int i = 0; i < 8; i++) req(4'd3, 8'd0);
    check_status("t4_drain");
    push_idx(4'd7);
    req(4'd3, 8'd0);
    req(4'd1, 8'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_held_extra", sb.size(), 0);
    req(4'd5, 8'd0);
    check_status("t5_invalid");
    issue(4'd2, 8'h33, 1'b0, 4'd0, 1'b1, 4'd7, 8'h55);
    issue(4'd1, 8'd0, 1'b0, 4'd0, 1'b1, 4'd7, 8'h99);
    req(4'd1, 8'd0);
    req(4'd3, 8'd0);
    req(4'd2, 8'd6);
    req(4'd1, 8'd0);
    push_idx(4'd5);
    req(4'd3, 8'd0);
    @(posedge clk); #1;
    bus.busreq = 4'd2;
    bus.alu_result = 8'hA5;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.busreq = 4'd0;
    #1;
    model_reset();
    chk("t6_operand", bus.operand, 0);
    chk("t6_regval", bus.regval, 0);
    chk("t6_resp_valid", bus.resp_valid, 0);
    check_status("t6");
    @(posedge clk); #1;
    rst = 1'b0;
    push_idx(4'd5);
    req(4'd3, 8'd0);
    req(4'd1, 8'd0);
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [3:0] ca;
      r = $urandom_range(0, 9);
      ca = $urandom_range(0, 1) ? m_sel : 4'($urandom_range(0, NR - 1));
      if (r < 2) push_idx(4'($urandom_range(0, NR - 1)));
      else if (r == 2) preload(4'($urandom_range(0, NR - 1)), 8'($urandom));
      else if (r == 9) req(4'($urandom_range(4, 15)), 8'($urandom));
      else issue(4'($urandom_range(1, 3)), 8'($urandom), $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, NR - 1)), $urandom_range(0, 2) == 0, ca, 8'($urandom));
      check_status("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
